// File: rtl/atm_input_conditioner.sv
// Front-end conditioner for the ATM panel: synchronises and debounces the
// confirm button (with post-press lockout) and the 12-bit switch bank.
module atm_input_conditioner #(
    parameter int unsigned DB_CYCLES      = 500000,
    parameter int unsigned LOCKOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_confirm_raw,
    input  logic [11:0] sw_raw,
    output logic        confirm_pulse,
    output logic        btn_held,
    output logic [1:0]  sw_card,
    output logic [2:0]  sw_menu,
    output logic [3:0]  sw_deposit,
    output logic [2:0]  sw_withdraw,
    output logic        sw_changed
);

    localparam int unsigned CW = 24;
    localparam logic [CW-1:0] DB_LIM = CW'(DB_CYCLES);
    localparam int unsigned LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam logic [LW-1:0] LOCKOUT_LIM = LW'(LOCKOUT_CYCLES);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    logic          btn_s1, btn_s2;
    logic [11:0]   sw_s1, sw_s2;

    btn_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          press_acc;
    logic [LW-1:0] lockout;
    logic          pulse_fire;

    logic [11:0]   sw_cand, sw_cand_nxt, sw_word;
    logic [CW-1:0] sw_cnt, sw_cnt_nxt, sw_cnt_inc;
    logic          sw_commit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_confirm_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_raw;
            sw_s2  <= sw_s1;
        end
    end

    assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
    assign sw_cnt_inc = (sw_cnt == '1) ? sw_cnt : sw_cnt + 1'b1;

    // The transition that enters a wait state restarts the count, so each
    // wait needs DB_CYCLES further stable samples before it resolves.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_acc = 1'b0;
        unique case (state)
            INIT: begin
                if (btn_s2) begin
                    cnt_nxt = '0;
                end else if (cnt_inc >= DB_LIM) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            IDLE: begin
                if (btn_s2) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= DB_LIM) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press_acc = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            PRESSED: begin
                if (!btn_s2) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= DB_LIM) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign pulse_fire = press_acc && (lockout == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= INIT;
            cnt           <= '0;
            lockout       <= '0;
            confirm_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            confirm_pulse <= pulse_fire;
            if (pulse_fire) begin
                lockout <= LOCKOUT_LIM;
            end else if (lockout != '0) begin
                lockout <= lockout - 1'b1;
            end
        end
    end

    assign btn_held = (state == PRESSED) || (state == RELEASE_WAIT);

    always_comb begin
        sw_cand_nxt = sw_cand;
        sw_cnt_nxt  = sw_cnt;
        sw_commit   = 1'b0;
        if (sw_s2 != sw_cand) begin
            sw_cand_nxt = sw_s2;
            sw_cnt_nxt  = '0;
        end else if (sw_cand == sw_word) begin
            sw_cnt_nxt = '0;
        end else if (sw_cnt_inc >= DB_LIM) begin
            sw_commit  = 1'b1;
            sw_cnt_nxt = '0;
        end else begin
            sw_cnt_nxt = sw_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_cand    <= '0;
            sw_cnt     <= '0;
            sw_word    <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_cand    <= sw_cand_nxt;
            sw_cnt     <= sw_cnt_nxt;
            sw_changed <= sw_commit;
            if (sw_commit) begin
                sw_word <= sw_cand;
            end
        end
    end

    assign sw_card     = sw_word[1:0];
    assign sw_menu     = sw_word[4:2];
    assign sw_deposit  = sw_word[8:5];
    assign sw_withdraw = sw_word[11:9];

endmodule

// File: tb/tb_atm_input_conditioner.sv
// Scoreboard bench for atm_input_conditioner: a run-length reference model
// queues expected pulses/commits, a negedge monitor pops and compares them.
module tb_atm_input_conditioner;

    localparam int DB = 4;
    localparam int LK = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_confirm_raw;
    logic [11:0] sw_raw;
    logic        confirm_pulse, btn_held, sw_changed;
    logic [1:0]  sw_card;
    logic [2:0]  sw_menu, sw_withdraw;
    logic [3:0]  sw_deposit;
    logic [11:0] dut_sw;

    atm_input_conditioner #(.DB_CYCLES(DB), .LOCKOUT_CYCLES(LK)) dut (
        .clk(clk), .rst(rst), .btn_confirm_raw(btn_confirm_raw), .sw_raw(sw_raw),
        .confirm_pulse(confirm_pulse), .btn_held(btn_held),
        .sw_card(sw_card), .sw_menu(sw_menu), .sw_deposit(sw_deposit),
        .sw_withdraw(sw_withdraw), .sw_changed(sw_changed)
    );

    assign dut_sw = {sw_withdraw, sw_deposit, sw_menu, sw_card};

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [11:0] sw;
        bit          chg;
    } ev_t;

    ev_t pulse_q[$];
    ev_t chg_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;

    // Reference model: filters by run length of the synchronised samples.
    logic        m_b1, m_b2;
    logic [11:0] m_w1, m_w2, m_last, m_comm;
    int          run1, run0, swrun, last_pulse;
    bit          ready, held, have_pulse;

    task automatic model_reset();
        m_b1 = 1'b0; m_b2 = 1'b0;
        m_w1 = '0; m_w2 = '0; m_last = '0; m_comm = '0;
        run1 = 0; run0 = 0; swrun = 0; last_pulse = 0;
        ready = 1'b0; held = 1'b0; have_pulse = 1'b0;
    endtask

    task automatic model_step();
        logic        b;
        logic [11:0] w;
        bit          committed;
        ev_t         e;
        cyc++;
        if (!rst) begin
            model_reset();
            return;
        end
        b = m_b2;
        w = m_w2;
        committed = 1'b0;
        if (w == m_last) swrun++;
        else begin
            m_last = w;
            swrun = 1;
        end
        if (swrun == DB + 1 && w != m_comm) begin
            m_comm = w;
            committed = 1'b1;
            e.cyc = cyc; e.sw = w; e.chg = 1'b1;
            chg_q.push_back(e);
        end
        if (b) begin run1++; run0 = 0; end
        else begin run0++; run1 = 0; end
        if (!ready) begin
            if (!b && run0 >= DB) ready = 1'b1;
        end else if (!held) begin
            if (b && run1 == DB + 1) begin
                held = 1'b1;
                if (!have_pulse || cyc >= last_pulse + LK + 1) begin
                    have_pulse = 1'b1;
                    last_pulse = cyc;
                    e.cyc = cyc; e.sw = m_comm; e.chg = committed;
                    pulse_q.push_back(e);
                end
            end
        end else if (!b && run0 == DB + 1) begin
            held = 1'b0;
        end
        m_b2 = m_b1; m_b1 = btn_confirm_raw;
        m_w2 = m_w1; m_w1 = sw_raw;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if ({confirm_pulse, btn_held, sw_changed, dut_sw} !== 15'd0) begin
                    failures++;
                    $display("FAIL reset_outputs cyc=%0d got %h expected 0", cyc,
                             {confirm_pulse, btn_held, sw_changed, dut_sw});
                end
            end else begin
                checks++;
                if (btn_held !== held || dut_sw !== m_comm) begin
                    failures++;
                    $display("FAIL held_sw cyc=%0d got held=%b sw=%h expected held=%b sw=%h",
                             cyc, btn_held, dut_sw, held, m_comm);
                end
                while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
                    e = pulse_q.pop_front();
                    checks++; failures++;
                    $display("FAIL pulse_missing got none expected pulse at cyc=%0d", e.cyc);
                end
                while (chg_q.size() > 0 && chg_q[0].cyc < cyc) begin
                    e = chg_q.pop_front();
                    checks++; failures++;
                    $display("FAIL sw_changed_missing got none expected %h at cyc=%0d", e.sw, e.cyc);
                end
                if (confirm_pulse) begin
                    checks++;
                    if (pulse_q.size() == 0) begin
                        failures++;
                        $display("FAIL pulse_unexpected cyc=%0d got pulse expected none", cyc);
                    end else begin
                        e = pulse_q.pop_front();
                        if (e.cyc != cyc || dut_sw !== e.sw || sw_changed !== e.chg) begin
                            failures++;
                            $display("FAIL pulse cyc=%0d sw=%h chg=%b expected cyc=%0d sw=%h chg=%b",
                                     cyc, dut_sw, sw_changed, e.cyc, e.sw, e.chg);
                        end
                    end
                end
                if (sw_changed) begin
                    checks++;
                    if (chg_q.size() == 0) begin
                        failures++;
                        $display("FAIL sw_changed_unexpected cyc=%0d got pulse expected none", cyc);
                    end else begin
                        e = chg_q.pop_front();
                        if (e.cyc != cyc || dut_sw !== e.sw) begin
                            failures++;
                            $display("FAIL sw_changed cyc=%0d sw=%h expected cyc=%0d sw=%h",
                                     cyc, dut_sw, e.cyc, e.sw);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic btn_seg(input logic v, input int n);
        btn_confirm_raw = v;
        tick(n);
    endtask

    initial begin
        rst = 1'b0;
        btn_confirm_raw = 1'b0;
        sw_raw = '0;
        tick(3);
        rst = 1'b1;
        tick(8);

        // clean press
        btn_seg(1'b1, 20);
        btn_seg(1'b0, 20);

        // bounce every 2 cycles
        for (int i = 0; i < 15; i++) btn_seg((i % 2) == 0, 2);
        btn_seg(1'b0, 15);

        // second press inside lockout, third afterwards
        btn_seg(1'b1, 5); btn_seg(1'b0, 5); btn_seg(1'b1, 5);
        btn_seg(1'b0, 25); btn_seg(1'b1, 5); btn_seg(1'b0, 20);

        // one cycle later the lockout has just expired
        btn_seg(1'b1, 5); btn_seg(1'b0, 6); btn_seg(1'b1, 5); btn_seg(1'b0, 20);

        // presses 8 cycles apart
        btn_seg(1'b1, 5); btn_seg(1'b0, 3); btn_seg(1'b1, 5); btn_seg(1'b0, 30);

        // switch word, then a short glitch
        sw_raw = 12'hA5C; tick(15);
        sw_raw = 12'hFFF; tick(2);
        sw_raw = 12'hA5C; tick(15);
        checks++;
        if ({sw_withdraw, sw_deposit, sw_menu, sw_card} !== {3'd5, 4'd2, 3'd7, 2'd0}) begin
            failures++;
            $display("FAIL sw_fields got %h expected %h", dut_sw, 12'hA5C);
        end

        // button held through reset
        btn_seg(1'b1, 10);
        rst = 1'b0; tick(3);
        rst = 1'b1; tick(15);
        btn_seg(1'b0, 15);
        btn_seg(1'b1, 10);
        btn_seg(1'b0, 20);

        // switch commit and press on the same edge
        sw_raw = 12'h3C5;
        btn_seg(1'b1, 10);
        btn_seg(1'b0, 20);

        // random segments
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) sw_raw = 12'($urandom);
            btn_seg(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
        end
        btn_confirm_raw = 1'b0;
        tick(40);

        checks++;
        if (pulse_q.size() != 0) begin
            failures++;
            $display("FAIL pulse_queue_drain got %0d left expected 0", pulse_q.size());
        end
        checks++;
        if (chg_q.size() != 0) begin
            failures++;
            $display("FAIL chg_queue_drain got %0d left expected 0", chg_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
